// File: rtl/serial_frame_tx.sv
// Serial frame transmitter: parallel frames in via ready/load with one-deep holding
// register, shifted out LSB-first at clk/CLK_DIV with optional idle gap bits.
`timescale 1ns/1ps
module serial_frame_tx #(
  parameter int FRAME_W  = 10,
  parameter int CLK_DIV  = 5,
  parameter int GAP_BITS = 0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load_i,
  input  logic [FRAME_W-1:0] frame_i,
  output logic               ready_o,
  output logic               busy_o,
  output logic               data_o,
  output logic               bit_stb_o,
  output logic               done_o,
  output logic [7:0]         frames_o
);
  localparam int CNT_MAX = (FRAME_W > GAP_BITS) ? FRAME_W : GAP_BITS;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST   = DIV_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] FRAME_LAST = CNT_W'(FRAME_W - 1);
  localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'((GAP_BITS > 0) ? GAP_BITS - 1 : 0);

  typedef enum logic [1:0] {IDLE, SEND, GAP} state_e;

  state_e             state_q, state_d;
  logic [FRAME_W-1:0] shift_q, hold_q;
  logic               hold_full;
  logic [DIV_W-1:0]   div_q;
  logic [CNT_W-1:0]   bit_q;
  logic [7:0]         frames_q;

  logic acc, bit_end, frame_end, gap_end, start, xfer, store;

  assign ready_o   = !hold_full;
  assign busy_o    = (state_q != IDLE);
  assign data_o    = (state_q == SEND) && shift_q[0];
  assign bit_stb_o = (state_q == SEND) && (div_q == '0);
  assign done_o    = frame_end;
  assign frames_o  = frames_q;

  always_comb begin
    acc       = load_i && ready_o;
    bit_end   = (div_q == DIV_LAST);
    frame_end = (state_q == SEND) && bit_end && (bit_q == FRAME_LAST);
    gap_end   = (state_q == GAP) && bit_end && (bit_q == GAP_LAST);
    state_d   = state_q;
    start     = 1'b0;
    xfer      = 1'b0;
    case (state_q)
      IDLE: if (acc) begin state_d = SEND; start = 1'b1; end
      SEND: if (frame_end) begin
        if (GAP_BITS > 0)   state_d = GAP;
        else if (hold_full) xfer = 1'b1;
        // a frame offered on the boundary edge goes straight to the shifter
        else if (acc)       start = 1'b1;
        else                state_d = IDLE;
      end
      GAP: if (gap_end) begin
        if (hold_full)  begin state_d = SEND; xfer = 1'b1; end
        else if (acc)   begin state_d = SEND; start = 1'b1; end
        else            state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    store = acc && !start;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      shift_q   <= '0;
      hold_q    <= '0;
      hold_full <= 1'b0;
      div_q     <= '0;
      bit_q     <= '0;
      frames_q  <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE || bit_end) div_q <= '0;
      else                            div_q <= div_q + DIV_W'(1);
      if (state_q == IDLE || frame_end || gap_end) bit_q <= '0;
      else if (bit_end)                            bit_q <= bit_q + CNT_W'(1);
      if (start)                             shift_q <= frame_i;
      else if (xfer)                         shift_q <= hold_q;
      else if (state_q == SEND && bit_end)   shift_q <= {1'b0, shift_q[FRAME_W-1:1]};
      // store and xfer are exclusive: xfer needs hold_full, which blocks acceptance
      if (store) begin
        hold_q    <= frame_i;
        hold_full <= 1'b1;
      end else if (xfer) begin
        hold_full <= 1'b0;
      end
      if (frame_end) frames_q <= frames_q + 8'd1;
    end
  end
endmodule

// File: doc/serial_frame_tx.md
# serial_frame_tx

Serial frame transmitter that sits directly upstream of the serial pattern-matching stage and produces its `datain_i` bit stream. It accepts parallel frames through a ready/load handshake and buffers one pending frame. Each frame is shifted out LSB-first at a divided bit rate, with optional idle gap bits between frames. When 10'b1111011010 is sent, the downstream shift register holds exactly that value after the last bit.

## Interface
- `FRAME_W`, default 10: bits per frame; must be ≥ 2.
- `CLK_DIV`, default 5: clock cycles per serial bit; must be ≥ 1.
- `GAP_BITS`, default 0: idle bit periods (`data_o` = 0) inserted after every frame; may be 0.
- `clk` input, 1 bit: single system clock; all logic on the rising edge.
- `rst_n` input, 1 bit: asynchronous, active-low reset.
- `load_i` input, 1 bit: frame offer; a frame is accepted on a rising edge where `load_i` and `ready_o` are both 1.
- `frame_i` input, FRAME_W bits: frame to send; sampled only on acceptance.
- `ready_o` output, 1 bit: high when the holding register is empty.
- `busy_o` output, 1 bit: high in the SEND and GAP states.
- `data_o` output, 1 bit: serial bit stream; idle level is 0.
- `bit_stb_o` output, 1 bit: one-cycle pulse on the first cycle of each data bit (not asserted during gap bits).
- `done_o` output, 1 bit: one-cycle pulse on the final cycle of each frame's last data bit.
- `frames_o` output, 8 bits: count of completed frames; wraps from 255 to 0.

## Operation
- Registers:
  - Shift register, FRAME_W bits.
  - Holding register, FRAME_W bits, plus a `hold_full` flag.
  - Clock divider counter, 0..CLK_DIV-1.
  - Bit counter, 0..max(FRAME_W, GAP_BITS)-1.
- States:
  - IDLE: `data_o` = 0, `busy_o` = 0.
  - SEND: `data_o` = shift register bit 0. The register shifts right by one at each bit boundary.
  - GAP: `data_o` = 0 for GAP_BITS × CLK_DIV cycles.
- IDLE → SEND on acceptance. The frame loads directly into the shift register, and the holding register is unused.
- Acceptance in SEND or GAP stores the frame into the holding register and sets `hold_full`. `ready_o` = !`hold_full`, registered.
- End of the last bit in SEND:
  - GAP_BITS > 0: go to GAP.
  - Otherwise, if `hold_full`: move the holding register into the shift register, clear `hold_full`, and stay in SEND.
  - Otherwise: go to IDLE.
- End of GAP: if `hold_full`, transfer and go to SEND; else go to IDLE.
- Drain/load collision: on the edge where the holding register drains, `ready_o` was 0 for that cycle, so `load_i` is ignored. `ready_o` rises after that edge. No frame is ever lost or overwritten.
- `frames_o` increments on the same edge that ends a frame's last bit, i.e. the edge following the `done_o` cycle.
- In IDLE, `hold_full` is always 0.
- Reset (asynchronous, any time including mid-frame):
  - State → IDLE; all counters and registers cleared; any frame in flight or pending is discarded.
  - Output values during and after reset: `data_o` = 0, `busy_o` = 0, `bit_stb_o` = 0, `done_o` = 0, `frames_o` = 0, `ready_o` = 1.

## Timing
- Acceptance at edge k, from IDLE:
  - `data_o` = `frame_i[0]` and `bit_stb_o` = 1 right after edge k.
  - Bit i is driven from edge k + i·CLK_DIV for CLK_DIV cycles.
  - `done_o` is high after edge k + FRAME_W·CLK_DIV − 1, for one cycle.
  - Frame length is exactly FRAME_W·CLK_DIV cycles.
- Back-to-back with GAP_BITS = 0 and `hold_full`: the next frame's bit 0 is driven right after edge k + FRAME_W·CLK_DIV. There are no idle cycles between frames.
- With GAP_BITS > 0: the next frame starts GAP_BITS·CLK_DIV cycles after the previous frame ends.
- CLK_DIV = 1: one bit per clock. `bit_stb_o` stays high for the whole frame.
- `busy_o` falls on the edge where IDLE is entered.

## Test plan
- Single frame 10'b1111011010, CLK_DIV = 5, GAP_BITS = 0:
  - `data_o` = 0,1,0,1,1,0,1,1,1,1, each bit for 5 cycles.
  - `done_o` at cycle 49 after acceptance; `frames_o` = 1.
  - A downstream 10-bit right-shift register sampled mid-bit holds 10'b1111011010.
- Two frames, the second offered while busy, GAP_BITS = 0:
  - `ready_o` drops after the second acceptance.
  - A third `load_i` is ignored.
  - Frame 2 bit 0 follows immediately after cycle 50.
  - `ready_o` returns high one cycle after the transfer.
- GAP_BITS = 2, two queued frames: exactly 10 cycles of `data_o` = 0 between frames, with no `bit_stb_o` during the gap.
- Assert `rst_n` = 0 asynchronously during bit 4 of a frame:
  - Outputs immediately take their reset values.
  - The pending frame is discarded.
  - After release, `ready_o` = 1 and the next load sends a fresh frame.
- Send 256 frames: `frames_o` wraps to 0, and `done_o` pulses exactly 256 times.
- CLK_DIV = 1, frame 10'h3FF: `data_o` is high for 10 consecutive cycles, and `bit_stb_o` is high for all 10.
